ps2_keycode_rx: RTL and testbench

//  Receives device-to-host PS/2 keyboard frames (scan code set 2) and presents the

---
 rtl/ps2_keycode_rx.sv | 168 ++++++++++++++++
 tb/tb_ps2_keycode_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keycode_rx.sv
// PS/2 device-to-host receiver (scan code set 2).
// Synchronises and deglitches the keyboard clock, deserialises 11-bit frames,
// checks odd parity and the stop bit, and keeps the last two good bytes as a
// 16-bit keycode history with one-cycle valid / error pulses.
module ps2_keycode_rx #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] keycode,
    output logic        key_valid,
    output logic        frame_error
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [SYNC_STAGES-1:0] clk_sync_reg;
    logic [SYNC_STAGES-1:0] data_sync_reg;
    logic                   clk_synced;
    logic                   data_synced;

    logic [FW-1:0]          filt_cnt_reg;
    logic                   filt_reg;
    logic                   filt_prev_reg;
    logic                   fall;

    state_t                 state_reg, state_next;
    logic [2:0]             bitcnt_reg, bitcnt_next;
    logic [7:0]             shift_reg, shift_next;
    logic                   parity_reg, parity_next;
    logic [TW-1:0]          timeout_reg, timeout_next;
    logic [15:0]            keycode_reg, keycode_next;
    logic                   key_valid_reg, key_valid_next;
    logic                   frame_error_reg, frame_error_next;

    assign clk_synced  = clk_sync_reg[SYNC_STAGES-1];
    assign data_synced = data_sync_reg[SYNC_STAGES-1];

    // Metastability synchronisers for both PS/2 lines; idle level is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_sync_reg  <= '1;
            data_sync_reg <= '1;
        end else begin
            clk_sync_reg  <= {clk_sync_reg[SYNC_STAGES-2:0], ps2_clk};
            data_sync_reg <= {data_sync_reg[SYNC_STAGES-2:0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows the synced clock only after
    // FILTER_LEN consecutive samples disagree with the current filtered level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_cnt_reg  <= '0;
            filt_reg      <= 1'b1;
            filt_prev_reg <= 1'b1;
        end else begin
            filt_prev_reg <= filt_reg;
            if (clk_synced == filt_reg) begin
                filt_cnt_reg <= '0;
            end else if (filt_cnt_reg == FW'(FILTER_LEN - 1)) begin
                filt_reg     <= clk_synced;
                filt_cnt_reg <= '0;
            end else begin
                filt_cnt_reg <= filt_cnt_reg + FW'(1);
            end
        end
    end

    assign fall = filt_prev_reg & ~filt_reg;

    // Frame FSM, history register and output pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            bitcnt_reg      <= '0;
            shift_reg       <= '0;
            parity_reg      <= 1'b0;
            timeout_reg     <= '0;
            keycode_reg     <= '0;
            key_valid_reg   <= 1'b0;
            frame_error_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            bitcnt_reg      <= bitcnt_next;
            shift_reg       <= shift_next;
            parity_reg      <= parity_next;
            timeout_reg     <= timeout_next;
            keycode_reg     <= keycode_next;
            key_valid_reg   <= key_valid_next;
            frame_error_reg <= frame_error_next;
        end
    end

    // Next-state logic: bits are taken on filtered falling edges only; a
    // stalled partial frame is aborted by the timeout counter.
    always_comb begin
        state_next       = state_reg;
        bitcnt_next      = bitcnt_reg;
        shift_next       = shift_reg;
        parity_next      = parity_reg;
        keycode_next     = keycode_reg;
        key_valid_next   = 1'b0;
        frame_error_next = 1'b0;

        if (state_reg == IDLE || fall) begin
            timeout_next = '0;
        end else begin
            timeout_next = timeout_reg + TW'(1);
        end

        case (state_reg)
            IDLE: begin
                // A high data bit on a falling edge is not a start bit; ignore it.
                if (fall && !data_synced) begin
                    state_next  = DATA;
                    bitcnt_next = '0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_next  = {data_synced, shift_reg[7:1]};
                    bitcnt_next = bitcnt_reg + 3'd1;
                    if (bitcnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    parity_next = data_synced;
                    state_next  = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    state_next = IDLE;
                    if (data_synced && (^{shift_reg, parity_reg})) begin
                        keycode_next   = {keycode_reg[7:0], shift_reg};
                        key_valid_next = 1'b1;
                    end else begin
                        frame_error_next = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort once TIMEOUT_CYCLES clocks have passed without a falling edge.
        if (state_reg != IDLE && !fall && timeout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next       = IDLE;
            timeout_next     = '0;
            frame_error_next = 1'b1;
        end
    end

    assign keycode     = keycode_reg;
    assign key_valid   = key_valid_reg;
    assign frame_error = frame_error_reg;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Bench for ps2_keycode_rx: table of whole frames plus hand-written sequences
// for glitch filtering, timeout abort and reset in mid-frame.
`timescale 1ns/1ps
module tb_ps2_keycode_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keycode;
    logic        key_valid;
    logic        frame_error;

    ps2_keycode_rx #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (4),
        .TIMEOUT_CYCLES(5000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .keycode    (keycode),
        .key_valid  (key_valid),
        .frame_error(frame_error)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int kv_total = 0;
    int fe_total = 0;
    int both_total = 0;

    // Pulse counters, sampled on the falling edge away from register updates.
    always @(negedge clk) begin
        if (key_valid) kv_total++;
        if (frame_error) fe_total++;
        if (key_valid && frame_error) both_total++;
    end

    typedef struct {
        logic [7:0]  data;
        logic        par;
        logic        stop;
        logic [15:0] exp_key;
        int          exp_kv;
        int          exp_fe;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
    endtask

    // One PS/2 bit: data set while clock high, clock low 20 clk, period 40 clk.
    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(20);
        ps2_clk = 1'b1;
        wait_clk(10);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(s);
        ps2_data = 1'b1;
        wait_clk(20);
    endtask

    int  kv0, fe0, waited;
    bit  got_timeout;

    initial begin
        // Frames with hand-computed odd parity; keycode history carried row to row.
        vecs[0] = '{8'h45, 1'b0, 1'b1, 16'h0045, 1, 0};
        vecs[1] = '{8'hF0, 1'b1, 1'b1, 16'h45F0, 1, 0};
        vecs[2] = '{8'h45, 1'b0, 1'b1, 16'hF045, 1, 0};
        vecs[3] = '{8'h16, 1'b1, 1'b1, 16'hF045, 0, 1};  // bad parity
        vecs[4] = '{8'h16, 1'b0, 1'b0, 16'hF045, 0, 1};  // bad stop
        vecs[5] = '{8'h16, 1'b0, 1'b1, 16'h4516, 1, 0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 16'h1600, 1, 0};
        vecs[7] = '{8'hFF, 1'b1, 1'b1, 16'h00FF, 1, 0};
        vecs[8] = '{8'hFF, 1'b0, 1'b1, 16'h00FF, 0, 1};  // bad parity

        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(5);
        @(negedge clk);
        check("reset_keycode", {16'h0, keycode}, 32'h0);
        check("reset_key_valid", {31'h0, key_valid}, 32'h0);
        check("reset_frame_error", {31'h0, frame_error}, 32'h0);
        reset = 1'b0;
        wait_clk(10);

        for (int i = 0; i < 9; i++) begin
            kv0 = kv_total;
            fe0 = fe_total;
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop);
            @(negedge clk);
            $display("vec %0d data=%02h par=%0b stop=%0b keycode=%04h kv=%0d fe=%0d",
                     i, vecs[i].data, vecs[i].par, vecs[i].stop, keycode,
                     kv_total - kv0, fe_total - fe0);
            check($sformatf("vec%0d_keycode", i), {16'h0, keycode}, {16'h0, vecs[i].exp_key});
            check($sformatf("vec%0d_kv_cycles", i), kv_total - kv0, vecs[i].exp_kv);
            check($sformatf("vec%0d_fe_cycles", i), fe_total - fe0, vecs[i].exp_fe);
        end

        // Short clock-low glitches of 1..3 clk. Data is held low so a glitch
        // wrongly accepted as an edge would start a frame and corrupt the next one.
        kv0 = kv_total;
        fe0 = fe_total;
        ps2_data = 1'b0;
        for (int n = 1; n < 4; n++) begin
            @(posedge clk);
            ps2_clk = 1'b0;
            wait_clk(n);
            ps2_clk = 1'b1;
            wait_clk(15);
        end
        ps2_data = 1'b1;
        wait_clk(20);
        $display("glitch kv=%0d fe=%0d", kv_total - kv0, fe_total - fe0);
        check("glitch_kv", kv_total - kv0, 0);
        check("glitch_fe", fe_total - fe0, 0);
        kv0 = kv_total;
        send_frame(8'h1E, 1'b1, 1'b1);
        @(negedge clk);
        $display("after glitch 1E keycode=%04h", keycode);
        check("glitch_then_1e_keycode", {16'h0, keycode}, 32'h0000FF1E);
        check("glitch_then_1e_kv", kv_total - kv0, 1);

        // Start + 5 data bits, then the clock stays high until the timeout fires.
        kv0 = kv_total;
        fe0 = fe_total;
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(i[0]);
        got_timeout = 1'b0;
        waited = 0;
        while (!got_timeout && waited < 6000) begin
            @(negedge clk);
            waited++;
            if (fe_total != fe0) got_timeout = 1'b1;
        end
        $display("timeout got=%0b waited=%0d", got_timeout, waited);
        check("timeout_seen", {31'h0, got_timeout}, 32'h1);
        check("timeout_not_early", {31'h0, (waited >= 4900 && waited <= 5000)}, 32'h1);
        wait_clk(20);
        check("timeout_fe_cycles", fe_total - fe0, 1);
        check("timeout_kv", kv_total - kv0, 0);
        check("timeout_keycode", {16'h0, keycode}, 32'h0000FF1E);
        kv0 = kv_total;
        send_frame(8'h26, 1'b0, 1'b1);
        @(negedge clk);
        $display("after timeout 26 keycode=%04h", keycode);
        check("timeout_then_26_keycode", {16'h0, keycode}, 32'h00001E26);
        check("timeout_then_26_kv", kv_total - kv0, 1);

        // Reset asserted during the parity bit of a 0x25 frame.
        kv0 = kv_total;
        fe0 = fe_total;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] b25;
            b25 = 8'h25;
            send_bit(b25[i]);
        end
        ps2_data = 1'b0;
        wait_clk(10);
        ps2_clk = 1'b0;
        wait_clk(10);
        #2 reset = 1'b1;
        #1;
        $display("midframe reset keycode=%04h kv=%0b fe=%0b", keycode, key_valid, frame_error);
        check("midreset_keycode", {16'h0, keycode}, 32'h0);
        check("midreset_kv", {31'h0, key_valid}, 32'h0);
        check("midreset_fe", {31'h0, frame_error}, 32'h0);
        wait_clk(5);
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_clk(10);
        @(negedge clk);
        reset = 1'b0;
        wait_clk(20);
        check("midreset_no_pulse_kv", kv_total - kv0, 0);
        check("midreset_no_pulse_fe", fe_total - fe0, 0);
        send_frame(8'h2E, 1'b1, 1'b1);
        @(negedge clk);
        $display("after reset 2E keycode=%04h kv=%0d fe=%0d", keycode, kv_total - kv0, fe_total - fe0);
        check("postreset_keycode", {16'h0, keycode}, 32'h0000002E);
        check("postreset_kv", kv_total - kv0, 1);
        check("postreset_fe", fe_total - fe0, 0);

        check("kv_fe_never_together", both_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
